// File: rtl/hci_arbiter_rr_pipe_pkg.sv
// Shared helpers and configuration types for the round-robin HCI arbiter.
package hci_arbiter_rr_pipe_pkg;

  localparam int unsigned HCI_ARB_MAX_REQ = 32;
  localparam int unsigned HCI_ARB_MAX_SW  = 16;

  // Width of an initiator index; never below one bit.
  function automatic int unsigned hci_arb_idx_w(input int unsigned nb_req);
    return (nb_req > 1) ? $clog2(nb_req) : 1;
  endfunction

  localparam int unsigned HCI_ARB_IDX_W = hci_arb_idx_w(4);

  typedef struct packed {
    logic [HCI_ARB_MAX_REQ-1:0] prio_mask;
    logic [HCI_ARB_MAX_SW-1:0]  starve_max;
  } hci_arb_cfg_t;

endpackage

// File: rtl/hci_arbiter_rr_chan.sv
// One arbitration channel: round-robin arbiter with priority mask and
// starvation escape, optional request slot, and in-order source-ID FIFO.
module hci_arbiter_rr_chan
  import hci_arbiter_rr_pipe_pkg::*;
#(
  parameter int unsigned NB_REQUESTS     = 4,
  parameter int unsigned AW              = 32,
  parameter int unsigned DW              = 32,
  parameter int unsigned REQ_PIPE        = 1,
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter int unsigned SW              = 8
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        clear_i,
  input  logic [NB_REQUESTS-1:0]      prio_mask_i,
  input  logic [SW-1:0]               starve_max_i,
  input  logic [NB_REQUESTS-1:0]      req_i,
  output logic [NB_REQUESTS-1:0]      gnt_o,
  input  logic [NB_REQUESTS*AW-1:0]   add_i,
  input  logic [NB_REQUESTS-1:0]      wen_i,
  input  logic [NB_REQUESTS*DW-1:0]   data_i,
  input  logic [NB_REQUESTS*(DW/8)-1:0] be_i,
  output logic [NB_REQUESTS-1:0]      r_valid_o,
  output logic [NB_REQUESTS*DW-1:0]   r_data_o,
  output logic                        out_req_o,
  input  logic                        out_gnt_i,
  output logic [AW-1:0]               out_add_o,
  output logic                        out_wen_o,
  output logic [DW-1:0]               out_data_o,
  output logic [DW/8-1:0]             out_be_o,
  input  logic                        out_r_valid_i,
  input  logic [DW-1:0]               out_r_data_i,
  output logic                        err_o
);

  localparam int unsigned IDX_W = hci_arb_idx_w(NB_REQUESTS);
  localparam int unsigned BW    = DW / 8;
  localparam int unsigned PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING) + 1;

  logic [IDX_W-1:0]       rr_ptr_q, rr_ptr_d, win_idx, push_idx, head_idx;
  logic [SW-1:0]          starve_q, starve_d;
  logic [NB_REQUESTS-1:0] hp_req, cand;
  logic                   lp_present, force_lp, win_v, accept, space, pop, push, slot_v_q;
  logic [AW-1:0]          sel_add;
  logic                   sel_wen;
  logic [DW-1:0]          sel_data;
  logic [BW-1:0]          sel_be;
  logic [IDX_W-1:0]       fifo_q [MAX_OUTSTANDING];
  logic [PTR_W-1:0]       wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]       cnt_q, occupancy;
  logic                   err_q;

  assign hp_req     = req_i & prio_mask_i;
  assign lp_present = |(req_i & ~prio_mask_i);
  assign force_lp   = (starve_max_i != '0) && (starve_q == starve_max_i);
  assign cand       = (|hp_req && !force_lp) ? hp_req : req_i;

  always_comb begin
    int k;
    logic [IDX_W-1:0] k_idx;
    win_v   = 1'b0;
    win_idx = '0;
    k       = 0;
    k_idx   = '0;
    for (int i = 0; i < NB_REQUESTS; i++) begin
      k     = (int'(rr_ptr_q) + i) % NB_REQUESTS;
      k_idx = IDX_W'(k);
      if (!win_v && cand[k_idx]) begin
        win_v   = 1'b1;
        win_idx = k_idx;
      end
    end
  end

  assign sel_add  = add_i[int'(win_idx)*AW +: AW];
  assign sel_wen  = wen_i[win_idx];
  assign sel_data = data_i[int'(win_idx)*DW +: DW];
  assign sel_be   = be_i[int'(win_idx)*BW +: BW];

  // Space is reserved for the slot occupant too, so a drain never overflows the FIFO.
  assign pop       = out_r_valid_i && (cnt_q != '0);
  assign occupancy = cnt_q + CNT_W'(slot_v_q);
  assign space     = (occupancy < CNT_W'(MAX_OUTSTANDING)) || pop;
  assign head_idx  = fifo_q[rd_ptr_q];

  generate
    if (REQ_PIPE != 0) begin : g_pipe
      logic [AW-1:0]    add_q;
      logic             wen_q;
      logic [DW-1:0]    data_q;
      logic [BW-1:0]    be_q;
      logic [IDX_W-1:0] idx_q;
      logic             drain;

      assign drain  = slot_v_q & out_gnt_i;
      assign accept = win_v && space && (!slot_v_q || out_gnt_i);

      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          slot_v_q <= 1'b0;
          add_q    <= '0;
          wen_q    <= 1'b0;
          data_q   <= '0;
          be_q     <= '0;
          idx_q    <= '0;
        end else if (clear_i) begin
          slot_v_q <= 1'b0;
          add_q    <= '0;
          wen_q    <= 1'b0;
          data_q   <= '0;
          be_q     <= '0;
          idx_q    <= '0;
        end else if (accept) begin
          slot_v_q <= 1'b1;
          add_q    <= sel_add;
          wen_q    <= sel_wen;
          data_q   <= sel_data;
          be_q     <= sel_be;
          idx_q    <= win_idx;
        end else if (drain) begin
          slot_v_q <= 1'b0;
        end
      end

      assign push       = drain;
      assign push_idx   = idx_q;
      assign out_req_o  = slot_v_q;
      assign out_add_o  = slot_v_q ? add_q : '0;
      assign out_wen_o  = slot_v_q & wen_q;
      assign out_data_o = slot_v_q ? data_q : '0;
      assign out_be_o   = slot_v_q ? be_q : '0;
    end else begin : g_comb
      assign slot_v_q   = 1'b0;
      assign out_req_o  = win_v && space;
      assign accept     = out_req_o && out_gnt_i;
      assign push       = accept;
      assign push_idx   = win_idx;
      assign out_add_o  = out_req_o ? sel_add : '0;
      assign out_wen_o  = out_req_o & sel_wen;
      assign out_data_o = out_req_o ? sel_data : '0;
      assign out_be_o   = out_req_o ? sel_be : '0;
    end
  endgenerate

  always_comb begin
    gnt_o = '0;
    if (accept) gnt_o[win_idx] = 1'b1;
  end

  always_comb begin
    r_valid_o = '0;
    r_data_o  = '0;
    if (pop) begin
      r_valid_o[head_idx]                  = 1'b1;
      r_data_o[int'(head_idx)*DW +: DW]    = out_r_data_i;
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (accept) rr_ptr_d = (win_idx == IDX_W'(NB_REQUESTS-1)) ? '0 : win_idx + 1'b1;
    starve_d = starve_q;
    if (!lp_present)                                           starve_d = '0;
    else if (accept && force_lp)                               starve_d = '0;
    else if (accept && prio_mask_i[win_idx] && starve_q != '1) starve_d = starve_q + 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_ptr_q <= '0;
      starve_q <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
    end else if (clear_i) begin
      rr_ptr_q <= '0;
      starve_q <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      starve_q <= starve_d;
      if (push) wr_ptr_q <= (wr_ptr_q == PTR_W'(MAX_OUTSTANDING-1)) ? '0 : wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= (rd_ptr_q == PTR_W'(MAX_OUTSTANDING-1)) ? '0 : rd_ptr_q + 1'b1;
      cnt_q <= cnt_q + CNT_W'(push) - CNT_W'(pop);
      if (out_r_valid_i && cnt_q == '0) err_q <= 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) fifo_q[wr_ptr_q] <= push_idx;
  end

  assign err_o = err_q;

endmodule

// File: rtl/hci_arbiter_rr_pipe.sv
// N:1 round-robin HCI arbiter: NB_CHAN independent channels, each with
// priority/starvation control and in-order response routing.
module hci_arbiter_rr_pipe
  import hci_arbiter_rr_pipe_pkg::*;
#(
  parameter int unsigned NB_REQUESTS     = 4,
  parameter int unsigned NB_CHAN         = 16,
  parameter int unsigned AW              = 32,
  parameter int unsigned DW              = 32,
  parameter int unsigned REQ_PIPE        = 1,
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter int unsigned SW              = 8
) (
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  input  logic                                  clear_i,
  input  logic [NB_REQUESTS-1:0]                prio_mask_i,
  input  logic [SW-1:0]                         starve_max_i,
  input  logic [NB_CHAN*NB_REQUESTS-1:0]        in_req_i,
  output logic [NB_CHAN*NB_REQUESTS-1:0]        in_gnt_o,
  input  logic [NB_CHAN*NB_REQUESTS*AW-1:0]     in_add_i,
  input  logic [NB_CHAN*NB_REQUESTS-1:0]        in_wen_i,
  input  logic [NB_CHAN*NB_REQUESTS*DW-1:0]     in_data_i,
  input  logic [NB_CHAN*NB_REQUESTS*(DW/8)-1:0] in_be_i,
  output logic [NB_CHAN*NB_REQUESTS-1:0]        in_r_valid_o,
  output logic [NB_CHAN*NB_REQUESTS*DW-1:0]     in_r_data_o,
  output logic [NB_CHAN-1:0]                    out_req_o,
  input  logic [NB_CHAN-1:0]                    out_gnt_i,
  output logic [NB_CHAN*AW-1:0]                 out_add_o,
  output logic [NB_CHAN-1:0]                    out_wen_o,
  output logic [NB_CHAN*DW-1:0]                 out_data_o,
  output logic [NB_CHAN*(DW/8)-1:0]             out_be_o,
  input  logic [NB_CHAN-1:0]                    out_r_valid_i,
  input  logic [NB_CHAN*DW-1:0]                 out_r_data_i,
  output logic [NB_CHAN-1:0]                    err_o
);

  localparam int unsigned NR = NB_REQUESTS;
  localparam int unsigned BW = DW / 8;

  for (genvar c = 0; c < NB_CHAN; c++) begin : g_chan
    hci_arbiter_rr_chan #(
      .NB_REQUESTS    (NB_REQUESTS),
      .AW             (AW),
      .DW             (DW),
      .REQ_PIPE       (REQ_PIPE),
      .MAX_OUTSTANDING(MAX_OUTSTANDING),
      .SW             (SW)
    ) u_chan (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .clear_i      (clear_i),
      .prio_mask_i  (prio_mask_i),
      .starve_max_i (starve_max_i),
      .req_i        (in_req_i[c*NR +: NR]),
      .gnt_o        (in_gnt_o[c*NR +: NR]),
      .add_i        (in_add_i[c*NR*AW +: NR*AW]),
      .wen_i        (in_wen_i[c*NR +: NR]),
      .data_i       (in_data_i[c*NR*DW +: NR*DW]),
      .be_i         (in_be_i[c*NR*BW +: NR*BW]),
      .r_valid_o    (in_r_valid_o[c*NR +: NR]),
      .r_data_o     (in_r_data_o[c*NR*DW +: NR*DW]),
      .out_req_o    (out_req_o[c]),
      .out_gnt_i    (out_gnt_i[c]),
      .out_add_o    (out_add_o[c*AW +: AW]),
      .out_wen_o    (out_wen_o[c]),
      .out_data_o   (out_data_o[c*DW +: DW]),
      .out_be_o     (out_be_o[c*BW +: BW]),
      .out_r_valid_i(out_r_valid_i[c]),
      .out_r_data_i (out_r_data_i[c*DW +: DW]),
      .err_o        (err_o[c])
    );
  end

endmodule

// File: tb/tb_hci_arbiter_rr_pipe.sv
// Randomized and directed bench for hci_arbiter_rr_pipe against a queue-based
// transaction model of the arbitration, slot and response-ordering rules.
module tb_hci_arbiter_rr_pipe;
  import hci_arbiter_rr_pipe_pkg::*;

  localparam int NR = 4, NC = 2, AW = 16, DW = 16, BW = DW/8;
  localparam int MAXO = 2, SW = 8, REQ_PIPE = 1;
  localparam int RW = NC*NR;
  localparam int FW = AW + 1 + DW + BW;

  logic                 clk_i = 1'b0, rst_i, clear_i;
  logic [NR-1:0]        prio_mask_i;
  logic [SW-1:0]        starve_max_i;
  logic [RW-1:0]        in_req_i, in_gnt_o, in_wen_i, in_r_valid_o;
  logic [RW*AW-1:0]     in_add_i;
  logic [RW*DW-1:0]     in_data_i, in_r_data_o;
  logic [RW*BW-1:0]     in_be_i;
  logic [NC-1:0]        out_req_o, out_gnt_i, out_wen_o, out_r_valid_i, err_o;
  logic [NC*AW-1:0]     out_add_o;
  logic [NC*DW-1:0]     out_data_o, out_r_data_i;
  logic [NC*BW-1:0]     out_be_o;

  hci_arbiter_rr_pipe #(
    .NB_REQUESTS(NR), .NB_CHAN(NC), .AW(AW), .DW(DW),
    .REQ_PIPE(REQ_PIPE), .MAX_OUTSTANDING(MAXO), .SW(SW)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .clear_i(clear_i),
    .prio_mask_i(prio_mask_i), .starve_max_i(starve_max_i),
    .in_req_i(in_req_i), .in_gnt_o(in_gnt_o), .in_add_i(in_add_i),
    .in_wen_i(in_wen_i), .in_data_i(in_data_i), .in_be_i(in_be_i),
    .in_r_valid_o(in_r_valid_o), .in_r_data_o(in_r_data_o),
    .out_req_o(out_req_o), .out_gnt_i(out_gnt_i), .out_add_o(out_add_o),
    .out_wen_o(out_wen_o), .out_data_o(out_data_o), .out_be_o(out_be_o),
    .out_r_valid_i(out_r_valid_i), .out_r_data_i(out_r_data_i), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0, failures = 0;

  // Reference model state, per channel
  int             rr_m [NC];
  int             stv_m[NC];
  bit             err_m[NC];
  bit             slot_v_m[NC];
  int             slot_i_m[NC];
  logic [FW-1:0]  slot_f_m[NC];
  int             fq[NC][$];

  // Observations captured by step()
  logic [NR-1:0]    obs_gnt[NC], obs_rv[NC];
  logic [NR*DW-1:0] obs_rd[NC];
  logic [FW-1:0]    obs_f[NC];
  logic             obs_req[NC], obs_err[NC];
  int               dut_hs[NC];

  hci_arb_cfg_t cfg;

  int rr_exp[5] = '{0, 1, 2, 3, 0};
  int st_exp[8] = '{0, 0, 0, 2, 0, 0, 0, 2};
  int ord[3]    = '{3, 1, 2};
  logic [DW-1:0] dval[3] = '{16'hD000, 16'hD111, 16'hD222};
  int smax_tab[5] = '{0, 1, 2, 3, 5};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s t=%0t got=%h expected=%h", tag, $time, obs, exp);
    end
  endtask

  function automatic logic [FW-1:0] req_fields(input int c, input int r);
    int b;
    b = c*NR + r;
    return {in_add_i[b*AW +: AW], in_wen_i[b], in_data_i[b*DW +: DW], in_be_i[b*BW +: BW]};
  endfunction

  task automatic model_reset_chan(input int c);
    rr_m[c] = 0; stv_m[c] = 0; err_m[c] = 1'b0;
    slot_v_m[c] = 1'b0; slot_i_m[c] = 0; slot_f_m[c] = '0;
    fq[c].delete();
  endtask

  task automatic model_reset();
    for (int c = 0; c < NC; c++) model_reset_chan(c);
  endtask

  task automatic rand_fields();
    for (int b = 0; b < RW; b++) begin
      in_add_i[b*AW +: AW]  = AW'($urandom);
      in_data_i[b*DW +: DW] = DW'($urandom);
      in_be_i[b*BW +: BW]   = BW'($urandom);
      in_wen_i[b]           = 1'($urandom);
    end
  endtask

  task automatic drive_idle();
    in_req_i = '0; out_r_valid_i = '0; out_gnt_i = '1; clear_i = 1'b0;
  endtask

  task automatic auto_rsp(input int c);
    out_r_valid_i[c]           = (fq[c].size() != 0);
    out_r_data_i[c*DW +: DW]   = DW'($urandom);
  endtask

  // Called just after inputs are driven at a falling edge: checks, advances the model, waits one cycle.
  task automatic step();
    #2;
    for (int c = 0; c < NC; c++) begin
      logic [NR-1:0]    req, hp, cand, exp_gnt, exp_rv;
      logic [NR*DW-1:0] exp_rd;
      logic [FW-1:0]    exp_f;
      bit lp, frc, acc, pop, found, space;
      int w, head, k;
      req   = in_req_i[c*NR +: NR];
      hp    = req & prio_mask_i;
      lp    = (req & ~prio_mask_i) != '0;
      frc   = (starve_max_i != '0) && (stv_m[c] == int'(starve_max_i));
      cand  = (hp != '0 && !frc) ? hp : req;
      found = 1'b0; w = 0;
      for (int i = 0; i < NR; i++) begin
        k = (rr_m[c] + i) % NR;
        if (!found && cand[k]) begin found = 1'b1; w = k; end
      end
      pop   = out_r_valid_i[c] && fq[c].size() > 0;
      head  = pop ? fq[c][0] : 0;
      space = (fq[c].size() + int'(slot_v_m[c])) < MAXO || pop;
      acc   = found && space && (!slot_v_m[c] || out_gnt_i[c]);
      exp_gnt = '0; if (acc) exp_gnt[w] = 1'b1;
      exp_rv  = '0; exp_rd = '0;
      if (pop) begin exp_rv[head] = 1'b1; exp_rd[head*DW +: DW] = out_r_data_i[c*DW +: DW]; end
      exp_f = slot_v_m[c] ? slot_f_m[c] : '0;

      obs_gnt[c] = in_gnt_o[c*NR +: NR];
      obs_rv[c]  = in_r_valid_o[c*NR +: NR];
      obs_rd[c]  = in_r_data_o[c*NR*DW +: NR*DW];
      obs_f[c]   = {out_add_o[c*AW +: AW], out_wen_o[c], out_data_o[c*DW +: DW], out_be_o[c*BW +: BW]};
      obs_req[c] = out_req_o[c];
      obs_err[c] = err_o[c];
      if (out_req_o[c] && out_gnt_i[c]) dut_hs[c]++;

      chk($sformatf("gnt[%0d]", c),     64'(obs_gnt[c]), 64'(exp_gnt));
      chk($sformatf("out_req[%0d]", c), 64'(obs_req[c]), 64'(slot_v_m[c]));
      chk($sformatf("out_fld[%0d]", c), 64'(obs_f[c]),   64'(exp_f));
      chk($sformatf("r_valid[%0d]", c), 64'(obs_rv[c]),  64'(exp_rv));
      chk($sformatf("r_data[%0d]", c),  64'(obs_rd[c]),  64'(exp_rd));
      chk($sformatf("err[%0d]", c),     64'(obs_err[c]), 64'(err_m[c]));

      if (out_r_valid_i[c] && fq[c].size() == 0) err_m[c] = 1'b1;
      if (pop) void'(fq[c].pop_front());
      if (slot_v_m[c] && out_gnt_i[c]) fq[c].push_back(slot_i_m[c]);
      if (acc) begin
        slot_v_m[c] = 1'b1; slot_i_m[c] = w; slot_f_m[c] = req_fields(c, w);
        rr_m[c] = (w + 1) % NR;
      end else if (slot_v_m[c] && out_gnt_i[c]) begin
        slot_v_m[c] = 1'b0;
      end
      if (!lp)                                   stv_m[c] = 0;
      else if (acc && frc)                       stv_m[c] = 0;
      else if (acc && prio_mask_i[w] && stv_m[c] < (1 << SW) - 1) stv_m[c]++;
      if (clear_i) model_reset_chan(c);
    end
    @(negedge clk_i);
  endtask

  task automatic pulse_reset();
    drive_idle();
    rst_i = 1'b1;
    #2;
    chk("rst_gnt",    64'(in_gnt_o), 64'(0));
    chk("rst_rvalid", 64'(in_r_valid_o), 64'(0));
    chk("rst_rdata",  64'(in_r_data_o), 64'(0));
    chk("rst_outreq", 64'(out_req_o), 64'(0));
    chk("rst_outfld", 64'({out_add_o, out_wen_o}), 64'(0));
    chk("rst_outdat", 64'({out_data_o, out_be_o}), 64'(0));
    chk("rst_err",    64'(err_o), 64'(0));
    model_reset();
    @(negedge clk_i);
    rst_i = 1'b0;
  endtask

  initial begin
    int cnt, issued, rsp, hs0;
    logic [NR*DW-1:0] e;
    rst_i = 1'b1; clear_i = 1'b0; prio_mask_i = '0; starve_max_i = '0;
    in_req_i = '0; in_add_i = '0; in_wen_i = '0; in_data_i = '0; in_be_i = '0;
    out_gnt_i = '1; out_r_valid_i = '0; out_r_data_i = '0;
    for (int c = 0; c < NC; c++) dut_hs[c] = 0;
    model_reset();
    repeat (2) @(negedge clk_i);
    pulse_reset();

    // Round robin with all four requesting
    prio_mask_i = '0; starve_max_i = '0;
    for (int k = 0; k < 5; k++) begin
      drive_idle(); rand_fields();
      in_req_i[NR-1:0] = '1; auto_rsp(0);
      step();
      chk("rr_seq", 64'(obs_gnt[0]), 64'(1) << rr_exp[k]);
    end

    // Starvation escape: mask 0001, limit 3, inputs 0 and 2
    pulse_reset();
    prio_mask_i = 4'b0001; starve_max_i = 8'd3;
    for (int k = 0; k < 8; k++) begin
      drive_idle(); rand_fields();
      in_req_i[NR-1:0] = 4'b0101; auto_rsp(0);
      step();
      chk("starve_seq", 64'(obs_gnt[0]), 64'(1) << st_exp[k]);
    end

    // Stalled slot holds fields; forwarded exactly once
    pulse_reset();
    prio_mask_i = '0; starve_max_i = '0;
    drive_idle(); out_gnt_i = '0;
    in_add_i[AW-1:0] = 16'h1234; in_wen_i[0] = 1'b0; in_data_i[DW-1:0] = 16'hBEEF; in_be_i[BW-1:0] = 2'b11;
    in_req_i[0] = 1'b1;
    step();
    chk("stall_acc", 64'(obs_gnt[0]), 64'(1));
    for (int k = 0; k < 5; k++) begin
      step();
      chk("stall_gnt", 64'(obs_gnt[0]), 64'(0));
      chk("stall_fld", 64'(obs_f[0]), 64'({16'h1234, 1'b0, 16'hBEEF, 2'b11}));
    end
    hs0 = dut_hs[0];
    in_req_i[0] = 1'b0; out_gnt_i = '1;
    for (int k = 0; k < 3; k++) step();
    chk("stall_fwd", 64'(dut_hs[0] - hs0), 64'(1));

    // Outstanding limit with no responses
    pulse_reset();
    drive_idle(); rand_fields(); in_req_i[NR-1:0] = 4'b0010;
    cnt = 0;
    for (int k = 0; k < 5; k++) begin
      step();
      if (obs_gnt[0] != '0) cnt++;
    end
    chk("outst_acc", 64'(cnt), 64'(2));
    chk("outst_blk", 64'(obs_gnt[0]), 64'(0));
    out_r_valid_i[0] = 1'b1; out_r_data_i[DW-1:0] = 16'h5A5A;
    step();
    chk("outst_pop_acc", 64'(obs_gnt[0]), 64'(4'b0010));
    chk("outst_pop_rv",  64'(obs_rv[0]),  64'(4'b0010));

    // In-order response routing for reads from 3, 1, 2
    pulse_reset();
    issued = 0; rsp = 0;
    for (int k = 0; k < 30 && rsp < 3; k++) begin
      drive_idle(); rand_fields(); in_wen_i = '1;
      if (issued < 3) in_req_i[ord[issued]] = 1'b1;
      if (fq[0].size() != 0) begin
        out_r_valid_i[0] = 1'b1; out_r_data_i[DW-1:0] = dval[rsp];
      end
      step();
      if (obs_gnt[0] != '0) issued++;
      if (obs_rv[0] != '0) begin
        e = '0; e[ord[rsp]*DW +: DW] = dval[rsp];
        chk("ord_rv", 64'(obs_rv[0]), 64'(1) << ord[rsp]);
        chk("ord_rd", 64'(obs_rd[0]), 64'(e));
        rsp++;
      end
    end
    chk("ord_done", 64'(rsp), 64'(3));

    // Response with empty FIFO sets a sticky error
    pulse_reset();
    drive_idle(); out_r_valid_i[0] = 1'b1;
    step();
    drive_idle();
    for (int k = 0; k < 3; k++) begin
      step();
      chk("err_sticky", 64'(obs_err[0]), 64'(1));
    end
    chk("err_other_chan", 64'(obs_err[1]), 64'(0));
    for (int k = 0; k < 20; k++) begin
      rand_fields(); in_req_i = RW'($urandom);
      for (int c = 0; c < NC; c++) auto_rsp(c);
      step();
    end
    pulse_reset();
    drive_idle();
    step();
    chk("err_after_rst", 64'(obs_err[0]), 64'(0));

    // Randomized traffic
    for (int ph = 0; ph < 6; ph++) begin
      cfg.prio_mask  = HCI_ARB_MAX_REQ'($urandom);
      cfg.starve_max = HCI_ARB_MAX_SW'(smax_tab[$urandom_range(0, 4)]);
      prio_mask_i  = cfg.prio_mask[NR-1:0];
      starve_max_i = cfg.starve_max[SW-1:0];
      for (int k = 0; k < 100; k++) begin
        rand_fields();
        in_req_i  = RW'($urandom);
        clear_i   = ($urandom_range(0, 99) == 0);
        for (int c = 0; c < NC; c++) begin
          out_gnt_i[c]             = ($urandom_range(0, 3) != 0);
          out_r_valid_i[c]         = (fq[c].size() != 0) ? 1'($urandom) : ($urandom_range(0, 19) == 0);
          out_r_data_i[c*DW +: DW] = DW'($urandom);
        end
        step();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
